// File: rtl/vram_arb.sv
// Time-slot arbiter that shares one VRAM port between video reads and blitter accesses.
// Read data comes back through a two-stage owner tag pipeline to the requester's port.
module vram_arb #(
  parameter int BLIT_EVERY = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        video_ena_i,
  input  logic        vgen_sel_i,
  input  logic [15:0] vgen_addr_i,
  output logic [15:0] vgen_data_o,
  output logic        vgen_ack_o,
  output logic        blit_cycle_o,
  input  logic        blit_sel_i,
  input  logic        blit_wr_i,
  input  logic [15:0] blit_addr_i,
  input  logic [15:0] blit_data_i,
  output logic [15:0] blit_data_o,
  output logic        blit_ack_o,
  output logic        vram_sel_o,
  output logic        vram_wr_o,
  output logic [15:0] vram_addr_o,
  output logic [15:0] vram_data_o,
  input  logic [15:0] vram_data_i
);

  localparam logic [2:0] LAST_SLOT = 3'(BLIT_EVERY - 1);
  // With a period of one every slot belongs to the blitter.
  localparam bit VIDEO_SLOTS = (BLIT_EVERY > 1);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_BLIT = 2'd2
  } tag_t;

  logic [2:0]  r_slot_cnt;
  logic        r_blit_cycle;
  logic        r_blit_edge;
  logic        r_vram_sel;
  logic        r_vram_wr;
  logic [15:0] r_vram_addr;
  logic [15:0] r_vram_data;
  tag_t        r_tag1;
  logic        r_rd1;
  tag_t        r_tag2;
  logic [15:0] r_vgen_data;
  logic        r_vgen_ack;
  logic [15:0] r_blit_data;
  logic        r_blit_ack;

  logic w_slot_last;
  logic w_blit_take;
  logic w_vid_take;

  assign w_slot_last = (r_slot_cnt == LAST_SLOT);
  // r_blit_edge is blit_cycle_o from the previous cycle, marking a blit capture edge.
  assign w_blit_take = r_blit_edge && blit_sel_i;
  assign w_vid_take  = !r_blit_edge && VIDEO_SLOTS && video_ena_i && vgen_sel_i;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_slot_cnt   <= '0;
      r_blit_cycle <= 1'b0;
      r_blit_edge  <= 1'b0;
      r_vram_sel   <= 1'b0;
      r_vram_wr    <= 1'b0;
      r_vram_addr  <= '0;
      r_vram_data  <= '0;
      r_tag1       <= TAG_NONE;
      r_rd1        <= 1'b0;
      r_tag2       <= TAG_NONE;
      r_vgen_data  <= '0;
      r_vgen_ack   <= 1'b0;
      r_blit_data  <= '0;
      r_blit_ack   <= 1'b0;
    end else begin
      if (!video_ena_i || w_slot_last) begin
        r_slot_cnt <= '0;
      end else begin
        r_slot_cnt <= r_slot_cnt + 3'd1;
      end
      r_blit_cycle <= !video_ena_i || w_slot_last;
      r_blit_edge  <= r_blit_cycle;

      if (w_blit_take) begin
        r_vram_sel  <= 1'b1;
        r_vram_wr   <= blit_wr_i;
        r_vram_addr <= blit_addr_i;
        r_vram_data <= blit_data_i;
        r_tag1      <= TAG_BLIT;
        r_rd1       <= !blit_wr_i;
      end else if (w_vid_take) begin
        r_vram_sel  <= 1'b1;
        r_vram_wr   <= 1'b0;
        r_vram_addr <= vgen_addr_i;
        r_tag1      <= TAG_VID;
        r_rd1       <= 1'b1;
      end else begin
        r_vram_sel  <= 1'b0;
        r_vram_wr   <= 1'b0;
        r_tag1      <= TAG_NONE;
        r_rd1       <= 1'b0;
      end

      // Only reads travel down the tag pipe; writes never produce an ack.
      r_tag2 <= r_rd1 ? r_tag1 : TAG_NONE;

      r_vgen_ack <= (r_tag2 == TAG_VID);
      r_blit_ack <= (r_tag2 == TAG_BLIT);
      if (r_tag2 == TAG_VID) begin
        r_vgen_data <= vram_data_i;
      end
      if (r_tag2 == TAG_BLIT) begin
        r_blit_data <= vram_data_i;
      end
    end
  end

  assign blit_cycle_o = r_blit_cycle;
  assign vram_sel_o   = r_vram_sel;
  assign vram_wr_o    = r_vram_wr;
  assign vram_addr_o  = r_vram_addr;
  assign vram_data_o  = r_vram_data;
  assign vgen_data_o  = r_vgen_data;
  assign vgen_ack_o   = r_vgen_ack;
  assign blit_data_o  = r_blit_data;
  assign blit_ack_o   = r_blit_ack;

endmodule

// File: tb/tb_vram_arb.sv
// Directed bench for vram_arb (BLIT_EVERY=2) with a one-cycle-latency VRAM read model.
module tb_vram_arb;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        video_ena_i;
  logic        vgen_sel_i;
  logic [15:0] vgen_addr_i;
  logic [15:0] vgen_data_o;
  logic        vgen_ack_o;
  logic        blit_cycle_o;
  logic        blit_sel_i;
  logic        blit_wr_i;
  logic [15:0] blit_addr_i;
  logic [15:0] blit_data_i;
  logic [15:0] blit_data_o;
  logic        blit_ack_o;
  logic        vram_sel_o;
  logic        vram_wr_o;
  logic [15:0] vram_addr_o;
  logic [15:0] vram_data_o;
  logic [15:0] vram_data_i = 16'hEEEE;

  int total = 0;
  int bad   = 0;

  vram_arb #(.BLIT_EVERY(2)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .video_ena_i  (video_ena_i),
    .vgen_sel_i   (vgen_sel_i),
    .vgen_addr_i  (vgen_addr_i),
    .vgen_data_o  (vgen_data_o),
    .vgen_ack_o   (vgen_ack_o),
    .blit_cycle_o (blit_cycle_o),
    .blit_sel_i   (blit_sel_i),
    .blit_wr_i    (blit_wr_i),
    .blit_addr_i  (blit_addr_i),
    .blit_data_i  (blit_data_i),
    .blit_data_o  (blit_data_o),
    .blit_ack_o   (blit_ack_o),
    .vram_sel_o   (vram_sel_o),
    .vram_wr_o    (vram_wr_o),
    .vram_addr_o  (vram_addr_o),
    .vram_data_o  (vram_data_o),
    .vram_data_i  (vram_data_i)
  );

  always #5 clk = ~clk;

  // VRAM model: read data valid the cycle after a read strobe, junk otherwise.
  logic        pend = 1'b0;
  logic [15:0] pend_addr = 16'h0000;
  function automatic logic [15:0] vram_word(input logic [15:0] a);
    if (a == 16'h1234) return 16'hA5C3;
    return {a[7:0], a[15:8]} ^ 16'h3C3C;
  endfunction
  always @(posedge clk) begin
    #1;
    vram_data_i = pend ? vram_word(pend_addr) : 16'hEEEE;
    pend        = vram_sel_o && !vram_wr_o;
    pend_addr   = vram_addr_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_blit_cycle"}, 16'(blit_cycle_o), 16'h0);
    check({tag, "_vram_sel"},   16'(vram_sel_o),   16'h0);
    check({tag, "_vram_wr"},    16'(vram_wr_o),    16'h0);
    check({tag, "_vram_addr"},  vram_addr_o,       16'h0);
    check({tag, "_vram_data"},  vram_data_o,       16'h0);
    check({tag, "_vgen_data"},  vgen_data_o,       16'h0);
    check({tag, "_blit_data"},  blit_data_o,       16'h0);
    check({tag, "_vgen_ack"},   16'(vgen_ack_o),   16'h0);
    check({tag, "_blit_ack"},   16'(blit_ack_o),   16'h0);
  endtask

  initial begin
    reset_i = 1'b1; video_ena_i = 1'b1;
    vgen_sel_i = 1'b0; vgen_addr_i = 16'h0;
    blit_sel_i = 1'b0; blit_wr_i = 1'b0; blit_addr_i = 16'h0; blit_data_i = 16'h0;
    tick(); tick();
    check_reset_state("rst");
    reset_i = 1'b0;

    // Idle with video enabled: strobe alternates 0,1,0,1, no VRAM traffic.
    $display("txn idle slots");
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("idle_blit_cycle_%0d", k), 16'(blit_cycle_o), (k % 2 == 0) ? 16'h1 : 16'h0);
      check($sformatf("idle_vram_sel_%0d", k), 16'(vram_sel_o), 16'h0);
    end

    // Blit read of 0x1234 on blit edge 6.
    tick();
    $display("txn blit read addr=1234");
    blit_sel_i = 1'b1; blit_wr_i = 1'b0; blit_addr_i = 16'h1234;
    tick();
    check("bread_sel",  16'(vram_sel_o), 16'h1);
    check("bread_wr",   16'(vram_wr_o),  16'h0);
    check("bread_addr", vram_addr_o,     16'h1234);
    blit_sel_i = 1'b0;
    tick();
    check("bread_e1_ack", 16'(blit_ack_o), 16'h0);
    check("bread_e1_sel", 16'(vram_sel_o), 16'h0);
    tick();
    check("bread_ack",   16'(blit_ack_o), 16'h1);
    check("bread_data",  blit_data_o,     16'hA5C3);
    check("bread_vack",  16'(vgen_ack_o), 16'h0);
    tick();
    check("bread_ack_pulse", 16'(blit_ack_o), 16'h0);

    // Video request on blit edge 10 is ignored.
    $display("txn video request on blit edge addr=0300");
    vgen_sel_i = 1'b1; vgen_addr_i = 16'h0300;
    tick();
    check("vign_sel", 16'(vram_sel_o), 16'h0);
    vgen_sel_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("vign_ack_%0d", k), 16'(vgen_ack_o), 16'h0);
    end

    // Video read on edge 15, blit read on edge 16.
    tick();
    $display("txn video read 0100 then blit read 0200");
    vgen_sel_i = 1'b1; vgen_addr_i = 16'h0100;
    tick();
    check("vb_vsel",  16'(vram_sel_o), 16'h1);
    check("vb_vaddr", vram_addr_o,     16'h0100);
    vgen_sel_i = 1'b0;
    blit_sel_i = 1'b1; blit_wr_i = 1'b0; blit_addr_i = 16'h0200;
    tick();
    check("vb_bsel",  16'(vram_sel_o), 16'h1);
    check("vb_bwr",   16'(vram_wr_o),  16'h0);
    check("vb_baddr", vram_addr_o,     16'h0200);
    blit_sel_i = 1'b0;
    tick();
    check("vb_vack",   16'(vgen_ack_o), 16'h1);
    check("vb_vdata",  vgen_data_o,     16'h3C3D);
    check("vb_bnack",  16'(blit_ack_o), 16'h0);
    tick();
    check("vb_back",   16'(blit_ack_o), 16'h1);
    check("vb_bdata",  blit_data_o,     16'h3C3E);
    check("vb_vnack",  16'(vgen_ack_o), 16'h0);
    check("vb_vhold",  vgen_data_o,     16'h3C3D);

    // Blit read on edge 20, then reset discards it.
    tick();
    $display("txn blit read then reset");
    blit_sel_i = 1'b1; blit_wr_i = 1'b0; blit_addr_i = 16'h1234;
    tick();
    check("rr_sel", 16'(vram_sel_o), 16'h1);
    blit_sel_i = 1'b0; reset_i = 1'b1;
    tick();
    check_reset_state("rr");
    reset_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("rr_back_%0d", k), 16'(blit_ack_o), 16'h0);
      check($sformatf("rr_blit_cycle_%0d", k), 16'(blit_cycle_o), (k == 2) ? 16'h1 : 16'h0);
    end

    // Video disabled: every slot is a blit slot; four back-to-back writes.
    $display("txn video off, blit writes 0000..0003");
    video_ena_i = 1'b0;
    tick();
    check("voff_bc_4", 16'(blit_cycle_o), 16'h1);
    tick();
    check("voff_bc_5", 16'(blit_cycle_o), 16'h1);
    for (int k = 0; k < 4; k++) begin
      blit_sel_i = 1'b1; blit_wr_i = 1'b1; blit_addr_i = 16'(k); blit_data_i = 16'h1F20;
      tick();
      check($sformatf("wr%0d_sel", k),  16'(vram_sel_o), 16'h1);
      check($sformatf("wr%0d_wr", k),   16'(vram_wr_o),  16'h1);
      check($sformatf("wr%0d_addr", k), vram_addr_o,     16'(k));
      check($sformatf("wr%0d_data", k), vram_data_o,     16'h1F20);
      check($sformatf("wr%0d_ack", k),  16'({vgen_ack_o, blit_ack_o}), 16'h0);
    end
    blit_sel_i = 1'b0; blit_wr_i = 1'b0;
    tick();
    check("wr_idle_sel", 16'(vram_sel_o), 16'h0);
    check("wr_idle_ack", 16'({vgen_ack_o, blit_ack_o}), 16'h0);

    // Re-enable video, read on video edge 13, drop video_ena while in flight.
    $display("txn video read 0400 with video_ena drop in flight");
    video_ena_i = 1'b1;
    tick();
    tick();
    vgen_sel_i = 1'b1; vgen_addr_i = 16'h0400;
    tick();
    check("vd_sel",  16'(vram_sel_o), 16'h1);
    check("vd_addr", vram_addr_o,     16'h0400);
    vgen_sel_i = 1'b0; video_ena_i = 1'b0;
    tick();
    check("vd_bc",    16'(blit_cycle_o), 16'h1);
    check("vd_nack",  16'(vgen_ack_o),   16'h0);
    tick();
    check("vd_ack",   16'(vgen_ack_o),   16'h1);
    check("vd_data",  vgen_data_o,       16'h3C38);
    check("vd_bnack", 16'(blit_ack_o),   16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 SHALL have parameter BLIT_EVERY, default 2, meaning VRAM slot period in cycles when video is enabled, with one blit slot per period; legal range 1..8.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 reset_i  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 video_ena_i  in  1  1 = video shares VRAM; 0 = every slot is a blit slot.
REQ-005 vgen_sel_i  in  1  video read request, sampled in video slots only.
REQ-006 vgen_addr_i  in  16  video read address.
REQ-007 vgen_data_o  out  16  video read data; valid while vgen_ack_o=1.
REQ-008 vgen_ack_o  out  1  one-cycle pulse when video read data is valid.
REQ-009 blit_cycle_o  out  1  slot grant strobe to the blitter; registered.
REQ-010 blit_sel_i  in  1  blit access request, valid the cycle after blit_cycle_o.
REQ-011 blit_wr_i  in  1  1 = write, 0 = read; qualified by blit_sel_i.
REQ-012 blit_addr_i  in  16  blit address.
REQ-013 blit_data_i  in  16  blit write data.
REQ-014 blit_data_o  out  16  blit read data; valid while blit_ack_o=1.
REQ-015 blit_ack_o  out  1  one-cycle pulse when blit read data is valid.
REQ-016 vram_sel_o / vram_wr_o  out  1 / 1  VRAM strobe / write enable; registered.
REQ-017 vram_addr_o / vram_data_o  out  16 / 16  VRAM address / write data; registered.
REQ-018 vram_data_i  in  16  VRAM read data, valid the cycle after vram_sel_o=1, vram_wr_o=0.

Function
REQ-019 SHALL keep slot counter slot_cnt (3 bits) counting 0..BLIT_EVERY-1 and wrapping to 0 while video_ena_i=1; held at 0 while video_ena_i=0.
REQ-020 SHALL drive blit_cycle_o=1 in the cycle after any edge where slot_cnt==BLIT_EVERY-1, or where video_ena_i=0; else 0.
REQ-021 Blit capture edge: the edge ending a cycle in which blit_cycle_o was 1 in the previous cycle; all other edges are video capture edges.
REQ-022 Blit capture edge with blit_sel_i=1: vram_sel_o=1, vram_wr_o=blit_wr_i, vram_addr_o=blit_addr_i, vram_data_o=blit_data_i next cycle; tag=BLIT.
REQ-023 Video capture edge with vgen_sel_i=1 and video_ena_i=1: vram_sel_o=1, vram_wr_o=0, vram_addr_o=vgen_addr_i next cycle; tag=VID.
REQ-024 Capture edge without a qualifying request: vram_sel_o=0, vram_wr_o=0; addr/data hold; tag=NONE.
REQ-025 vgen_sel_i on a blit capture edge SHALL be ignored (no VRAM access, no ack); video retries.
REQ-026 Read tag (owner, read flag) SHALL pipeline 2 stages; at the edge after vram_data_i is valid, register it to the owner's data output and pulse its ack for exactly 1 cycle.
REQ-027 Read latency: request at capture edge E -> ack high in cycle E+3; writes produce no ack.
REQ-028 Non-owner data output SHALL hold its last value; at most one ack high per cycle.
REQ-029 video_ena_i 1->0 mid-period: slot_cnt to 0 at next edge; in-flight video reads still complete and ack.
REQ-030 BLIT_EVERY=1: blit_cycle_o constant 1 after reset; video never granted.
REQ-031 Throughput: one VRAM access per cycle max; back-to-back reads SHALL pipeline without stalls.

Reset
REQ-032 reset_i=1 at an edge: slot_cnt=0, tags=NONE, blit_cycle_o=0, vram_sel_o=0, vram_wr_o=0, vram_addr_o=0, vram_data_o=0, vgen_data_o=0, blit_data_o=0, vgen_ack_o=0, blit_ack_o=0.
REQ-033 Reset mid-operation SHALL discard in-flight reads (no ack afterwards); first blit_cycle_o no earlier than BLIT_EVERY cycles after reset release when video_ena_i=1, 1 cycle when 0.

Verification
REQ-034 BLIT_EVERY=2, video_ena_i=1, idle -> blit_cycle_o toggles 0,1,0,1; vram_sel_o stays 0.
REQ-035 video_ena_i=0, blit writes addr 0x0000..0x0003 data 0x1F20 each grant -> vram_wr_o=1 four consecutive cycles, addresses incrementing, no acks.
REQ-036 Blit read addr 0x1234, VRAM model returns 0xA5C3 -> blit_ack_o 1 cycle at E+3, blit_data_o=0xA5C3, vgen_ack_o=0.
REQ-037 Video read 0x0100 on video edge and blit read 0x0200 on the next blit edge -> vram_addr_o 0x0100 then 0x0200 consecutive cycles, vgen_ack_o then blit_ack_o next cycle.
REQ-038 vgen_sel_i=1 on a blit capture edge with blit_sel_i=0 -> no VRAM access, no vgen_ack_o.
REQ-039 Blit read issued, reset_i=1 next cycle -> no blit_ack_o; all outputs at reset values.
